// File: rtl/obi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obi_pkg : shared types and helpers for the OBI SRAM subordinate          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package obi_pkg;

   localparam int unsigned OBI_DATA_W   = 32;
   localparam logic [31:0] OBI_ERR_DATA = 32'hBADCAB1E;

   typedef struct packed {
      logic [OBI_DATA_W-1:0] rdata;
      logic                  err;
   } obi_resp_t;

   // Byte-offset field width; never zero so it can size a vector safely.
   function automatic int unsigned obi_boff_width(input int unsigned dw);
      return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/obi_resp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obi_resp_fifo : in-order response FIFO, any DEPTH >= 1                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module obi_resp_fifo
   import obi_pkg::*;
#(
   parameter int unsigned DEPTH   = 2,
   parameter type         entry_t = obi_resp_t,
   localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          push_i,
   input  entry_t        data_i,
   input  logic          pop_i,
   output entry_t        data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        store_q [DEPTH];
   logic          do_push, do_pop;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = store_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) store_q[wr_ptr_q] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/obi_sram_sbr_mo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obi_sram_sbr_mo : OBI subordinate SRAM, base/depth window, error resp,   |
// |                   multiple outstanding transactions, R backpressure      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module obi_sram_sbr_mo
   import obi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned DEPTH_WORDS     = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] ERR_DATA        = OBI_ERR_DATA
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    obi_req_i,
   output logic                    obi_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
   input  logic                    obi_we_i,
   input  logic [DATA_WIDTH/8-1:0] obi_be_i,
   input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
   output logic                    obi_rvalid_o,
   input  logic                    obi_rready_i,
   output logic [DATA_WIDTH-1:0]   obi_rdata_o,
   output logic                    obi_err_o
);

   localparam int unsigned BYTES  = DATA_WIDTH / 8;
   localparam int unsigned BOFF_W = obi_boff_width(DATA_WIDTH);
   localparam int unsigned SHIFT  = $clog2(BYTES);
   localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CW     = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS * BYTES);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic                  err;
   } resp_t;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      idx;
   logic                  misalign, err_acc, accept;
   logic                  fifo_full, fifo_empty;
   logic [CW-1:0]         fifo_count;
   resp_t                 push_resp, head_resp;

   assign offset = obi_addr_i - BASE_ADDR;
   assign idx    = IDX_W'(offset >> SHIFT);

   if (BYTES > 1) begin : g_align_chk
      assign misalign = |obi_addr_i[BOFF_W-1:0];
   end else begin : g_byte_wide
      assign misalign = 1'b0;
   end

   assign err_acc   = ({1'b0, offset} >= WIN_BYTES) | misalign;
   // Grant depends only on the registered FIFO state.
   assign obi_gnt_o = ~fifo_full;
   assign accept    = obi_req_i & obi_gnt_o;

   always_comb begin
      push_resp = '0;
      if (err_acc) begin
         push_resp.rdata = DATA_WIDTH'(ERR_DATA);
         push_resp.err   = 1'b1;
      end else if (!obi_we_i) begin
         push_resp.rdata = mem_q[idx];
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept && obi_we_i && !err_acc) begin
         for (int k = 0; k < BYTES; k++) begin
            if (obi_be_i[k]) mem_q[idx][8*k +: 8] <= obi_wdata_i[8*k +: 8];
         end
      end
   end

   obi_resp_fifo #(
      .DEPTH   (MAX_OUTSTANDING),
      .entry_t (resp_t)
   ) u_resp_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (accept),
      .data_i  (push_resp),
      .pop_i   (obi_rvalid_o & obi_rready_i),
      .data_o  (head_resp),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign obi_rvalid_o = (fifo_count != '0);
   assign obi_rdata_o  = fifo_empty ? '0 : head_resp.rdata;
   assign obi_err_o    = fifo_empty ? 1'b0 : head_resp.err;

endmodule
`default_nettype wire

// File: tb/tb_obi_sram_sbr_mo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_obi_sram_sbr_mo : randomized + directed bench with reference model    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_obi_sram_sbr_mo;

   localparam int unsigned MAXO = 2;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic        rready = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;

   int          n_cmp = 0;
   int          n_err = 0;
   int          rr_mode = 0;
   bit          mon_en = 1'b0;
   logic [31:0] mem_m [256];
   exp_t        exp_q [$];

   obi_sram_sbr_mo #(
      .ADDR_WIDTH      (32),
      .DATA_WIDTH      (32),
      .DEPTH_WORDS     (256),
      .BASE_ADDR       (32'h0),
      .MAX_OUTSTANDING (MAXO),
      .ERR_DATA        (32'hBADCAB1E)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .obi_req_i    (req),
      .obi_gnt_o    (gnt),
      .obi_addr_i   (addr),
      .obi_we_i     (we),
      .obi_be_i     (be),
      .obi_wdata_i  (wdata),
      .obi_rvalid_o (rvalid),
      .obi_rready_i (rready),
      .obi_rdata_o  (rdata),
      .obi_err_o    (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      case (rr_mode)
         0:       rready = 1'b0;
         1:       rready = 1'b1;
         default: rready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: a word window of 1 KiB at address 0, word-aligned only.
   task automatic model_accept();
      exp_t        e;
      logic [31:0] a;
      logic [31:0] w;
      a = addr;
      if (a >= 32'h400 || a[1:0] != 2'b00) begin
         e.data = 32'hBADCAB1E;
         e.err  = 1'b1;
      end else if (we) begin
         w = mem_m[a / 4];
         for (int k = 0; k < 4; k++)
            if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
         mem_m[a / 4] = w;
         e.data = 32'h0;
         e.err  = 1'b0;
      end else begin
         e.data = mem_m[a / 4];
         e.err  = 1'b0;
      end
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         check("gnt", 32'(gnt), 32'(exp_q.size() < MAXO));
         check("rvalid", 32'(rvalid), 32'(exp_q.size() != 0));
         if (!rvalid) begin
            check("idle_rdata", rdata, 32'h0);
            check("idle_err", 32'(err), 32'h0);
         end
         if (reset_i) begin
            exp_q.delete();
         end else begin
            if (rvalid && rready && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("resp_rdata", rdata, e.data);
               check("resp_err", 32'(err), 32'(e.err));
            end
            if (req && gnt) model_accept();
         end
      end
   end

   task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
      bit ok;
      addr  = a;
      we    = w;
      be    = b;
      wdata = d;
      req   = 1'b1;
      ok    = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (gnt) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      check("accept", 32'(ok), 32'h1);
   endtask

   task automatic idle();
      req = 1'b0;
      we  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check("drain", 32'(exp_q.size()), 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      int          kind;

      // 1: reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t1_gnt", 32'(gnt), 32'h1);
      check("t1_rvalid", 32'(rvalid), 32'h0);
      check("t1_rdata", rdata, 32'h0);
      check("t1_err", 32'(err), 32'h0);
      reset_i = 1'b0;
      @(posedge clk);
      #1;
      mon_en  = 1'b1;
      rr_mode = 1;

      for (int i = 0; i < 256; i++)
         do_req(32'(i * 4), 1'b1, 4'hF,
                (i == 1) ? 32'hDA7A5EAD : (i == 3) ? 32'h0 : $urandom);
      idle();
      drain();

      // 2: single read, latency one cycle
      do_req(32'h4, 1'b0, 4'h0, 32'h0);
      idle();
      @(negedge clk);
      check("t2_rvalid", 32'(rvalid), 32'h1);
      check("t2_rdata", rdata, 32'hDA7A5EAD);
      @(posedge clk);
      #1;

      // 3: byte-enabled write then readback
      do_req(32'hC, 1'b1, 4'b0101, 32'h1337C0DE);
      idle();
      @(negedge clk);
      check("t3_wr_rdata", rdata, 32'h0);
      check("t3_wr_err", 32'(err), 32'h0);
      @(posedge clk);
      #1;
      do_req(32'hC, 1'b0, 4'h0, 32'h0);
      idle();
      @(negedge clk);
      check("t3_rd", rdata, 32'h003700DE);
      @(posedge clk);
      #1;

      // 4: out-of-range and misaligned
      do_req(32'h400, 1'b0, 4'h0, 32'h0);
      do_req(32'h2, 1'b0, 4'h0, 32'h0);
      idle();
      @(negedge clk);
      check("t4_rdata", rdata, 32'hBADCAB1E);
      check("t4_err", 32'(err), 32'h1);
      @(posedge clk);
      #1;
      do_req(32'h0, 1'b0, 4'h0, 32'h0);
      do_req(32'h4, 1'b0, 4'h0, 32'h0);
      idle();
      drain();

      // 5: fill with rready low, then release
      rr_mode = 0;
      @(posedge clk);
      #1;
      fork
         begin
            do_req(32'h4, 1'b0, 4'h0, 32'h0);
            do_req(32'h0, 1'b0, 4'h0, 32'h0);
            do_req(32'h8, 1'b0, 4'h0, 32'h0);
            idle();
         end
         begin
            repeat (3) @(negedge clk);
            check("t5_full_gnt", 32'(gnt), 32'h0);
            @(negedge clk);
            check("t5_stall_gnt", 32'(gnt), 32'h0);
            rr_mode = 1;
            @(negedge clk);
            check("t5_pop_rready", 32'(rready), 32'h1);
            check("t5_gnt_at_pop", 32'(gnt), 32'h0);
            @(negedge clk);
            check("t5_gnt_after_pop", 32'(gnt), 32'h1);
         end
      join
      drain();

      // 6: reset drops outstanding responses, memory survives
      rr_mode = 0;
      @(posedge clk);
      #1;
      do_req(32'h4, 1'b0, 4'h0, 32'h0);
      do_req(32'h0, 1'b0, 4'h0, 32'h0);
      idle();
      reset_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t6_rvalid", 32'(rvalid), 32'h0);
      check("t6_gnt", 32'(gnt), 32'h1);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      rr_mode = 1;
      @(posedge clk);
      #1;
      do_req(32'h4, 1'b0, 4'h0, 32'h0);
      idle();
      @(negedge clk);
      check("t6_rdata", rdata, 32'hDA7A5EAD);
      @(posedge clk);
      #1;

      // Randomized traffic with random backpressure
      rr_mode = 2;
      for (int t = 0; t < 400; t++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 0)      a = ($urandom | 32'h400) & ~32'h3;
         else if (kind == 1) a = {22'h0, 8'($urandom_range(0, 255)), 2'b00} + 32'($urandom_range(1, 3));
         else                a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         do_req(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
         end
      end
      idle();
      rr_mode = 1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
